// File: rtl/outfifo_read_sched_if.sv
// outfifo_read_sched_if
// Bundles the scheduler's FIFO-pop handshake, issue handshake and per-port
// scratchpad read selects.
//
// Signals
//   instr_FIFO_empty : instruction FIFO empty (FIFO -> scheduler)
//   instr_FIFO_rdata : head word {mat, row_cnt}, first-word-fall-through
//   instr_FIFO_REN   : pop the head word (scheduler -> FIFO)
//   issue_ready      : downstream accepts the current row group
//   r_valid          : per-port read valid
//   r_mat_sel        : per-port matrix select, port i at [i*MAT_W +: MAT_W]
//   r_row_sel        : per-port row select, port i at [i*ROW_W +: ROW_W]
//   busy             : scheduler not idle
//   cnt_err          : sticky, a row_cnt above ROWS_PER_MAT was seen
//
// Modports
//   master : the scheduler side
//   slave  : the FIFO / downstream side
interface outfifo_read_sched_if #(
  parameter int NUM_PORTS = 4,
  parameter int MAT_W     = 2,
  parameter int ROW_W     = 2
);

  logic                       instr_FIFO_empty;
  logic [MAT_W+ROW_W:0]       instr_FIFO_rdata;
  logic                       instr_FIFO_REN;
  logic                       issue_ready;
  logic [NUM_PORTS-1:0]       r_valid;
  logic [NUM_PORTS*MAT_W-1:0] r_mat_sel;
  logic [NUM_PORTS*ROW_W-1:0] r_row_sel;
  logic                       busy;
  logic                       cnt_err;

  modport master (
    input  instr_FIFO_empty,
    input  instr_FIFO_rdata,
    input  issue_ready,
    output instr_FIFO_REN,
    output r_valid,
    output r_mat_sel,
    output r_row_sel,
    output busy,
    output cnt_err
  );

  modport slave (
    output instr_FIFO_empty,
    output instr_FIFO_rdata,
    output issue_ready,
    input  instr_FIFO_REN,
    input  r_valid,
    input  r_mat_sel,
    input  r_row_sel,
    input  busy,
    input  cnt_err
  );

endinterface

// File: rtl/outfifo_read_sched.sv
// outfifo_read_sched
// Read-port scheduler for the output FIFO path. Pops {mat, row_cnt} words from
// a first-word-fall-through instruction FIFO and spreads the rows of each word
// across NUM_PORTS scratchpad read ports, one row group per accepted cycle.
// Consecutive words issue back-to-back with no idle cycle in between.
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST        : synchronous active-high reset
//   sched_if   : outfifo_read_sched_if.master (FIFO pop, issue handshake,
//                per-port read selects, busy, cnt_err)
//   perf_rows  : rows accepted downstream (only with OUTFIFO_SCHED_PERF_EN)
//   perf_stall : ISSUE cycles with issue_ready low (only with
//                OUTFIFO_SCHED_PERF_EN)
//
// Optional feature macro: OUTFIFO_SCHED_PERF_EN
//   Adds the two saturating 32-bit performance counters above. Without it the
//   counters and their ports do not exist.
//
// State | meaning
// IDLE  | no instruction held; pops the head word whenever the FIFO has one
// ISSUE | presenting row groups of the latched instruction to the read ports
module outfifo_read_sched #(
  parameter int NUM_PORTS = 4,
  parameter int MAT_W     = 2,
  parameter int ROW_W     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  outfifo_read_sched_if.master sched_if
`ifdef OUTFIFO_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_rows,
  output logic [31:0]          perf_stall
`endif
);

  localparam int ROWS_PER_MAT = 2 ** ROW_W;
  // row counts and the base pointer need one extra bit to hold ROWS_PER_MAT
  localparam int CNT_W        = ROW_W + 1;
  // wide enough for base + NUM_PORTS without wrapping
  localparam int SUM_W        = CNT_W + $clog2(NUM_PORTS) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [MAT_W-1:0]           r_mat;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           r_base;
  logic                       r_cnt_err;

  logic [MAT_W-1:0]           w_word_mat;
  logic [CNT_W-1:0]           w_word_cnt;
  logic [CNT_W-1:0]           w_word_cnt_clamp;
  logic                       w_word_over;
  logic                       w_word_zero;
  logic [SUM_W-1:0]           w_base_ext;
  logic [SUM_W-1:0]           w_cnt_ext;
  logic [SUM_W-1:0]           w_next_base;
  logic                       w_last_grp;
  logic                       w_issuing;
  logic                       w_ren;
  logic                       w_load;
  logic                       w_advance;
  logic [NUM_PORTS-1:0]       w_valid;
  logic [NUM_PORTS*MAT_W-1:0] w_mat_sel;
  logic [NUM_PORTS*ROW_W-1:0] w_row_sel;

  // head word decode
  assign w_word_mat       = sched_if.instr_FIFO_rdata[MAT_W+ROW_W -: MAT_W];
  assign w_word_cnt       = sched_if.instr_FIFO_rdata[CNT_W-1:0];
  assign w_word_over      = (w_word_cnt > CNT_W'(ROWS_PER_MAT));
  assign w_word_zero      = (w_word_cnt == '0);
  assign w_word_cnt_clamp = w_word_over ? CNT_W'(ROWS_PER_MAT) : w_word_cnt;

  assign w_issuing   = (r_state == ST_ISSUE);
  assign w_base_ext  = SUM_W'(r_base);
  assign w_cnt_ext   = SUM_W'(r_cnt);
  assign w_next_base = w_base_ext + SUM_W'(NUM_PORTS);
  assign w_last_grp  = (w_next_base >= w_cnt_ext);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!sched_if.instr_FIFO_empty) begin
          w_ren  = 1'b1;
          w_load = 1'b1;
          // a zero-row word is consumed and dropped
          if (!w_word_zero) begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (sched_if.issue_ready) begin
          if (w_last_grp) begin
            // chain straight into the next word so the ports never idle
            if (!sched_if.instr_FIFO_empty) begin
              w_ren       = 1'b1;
              w_load      = 1'b1;
              w_state_nxt = w_word_zero ? ST_IDLE : ST_ISSUE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // reset abandons the current instruction and must not consume a word
    if (RST) begin
      w_ren       = 1'b0;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mat     <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_cnt_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_mat  <= w_word_mat;
        r_cnt  <= w_word_cnt_clamp;
        r_base <= '0;
        if (w_word_over) begin
          r_cnt_err <= 1'b1;
        end
      end else if (w_advance) begin
        // only reached when base + NUM_PORTS < cnt, so it fits CNT_W bits
        r_base <= w_next_base[CNT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [SUM_W-1:0] w_row;
    assign w_row = w_base_ext + SUM_W'(g);
    assign w_valid[g] = w_issuing && (w_row < w_cnt_ext);
    assign w_mat_sel[g*MAT_W +: MAT_W] = w_issuing ? r_mat : '0;
    assign w_row_sel[g*ROW_W +: ROW_W] = w_issuing ? w_row[ROW_W-1:0] : '0;
  end

  assign sched_if.instr_FIFO_REN = w_ren;
  assign sched_if.r_valid        = w_valid;
  assign sched_if.r_mat_sel      = w_mat_sel;
  assign sched_if.r_row_sel      = w_row_sel;
  assign sched_if.busy           = w_issuing;
  assign sched_if.cnt_err        = r_cnt_err;

`ifdef OUTFIFO_SCHED_PERF_EN
  localparam int PC_W = $clog2(NUM_PORTS + 1);

  logic [31:0]     r_perf_rows;
  logic [31:0]     r_perf_stall;
  logic [PC_W-1:0] w_grp_rows;
  logic [32:0]     w_rows_sum;
  logic            w_accept;
  logic            w_stall;

  always_comb begin
    w_grp_rows = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_grp_rows = w_grp_rows + PC_W'(w_valid[i]);
    end
  end

  assign w_accept   = w_issuing && sched_if.issue_ready;
  assign w_stall    = w_issuing && !sched_if.issue_ready;
  assign w_rows_sum = {1'b0, r_perf_rows} + 33'(w_grp_rows);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_rows  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept) begin
        r_perf_rows <= w_rows_sum[32] ? '1 : w_rows_sum[31:0];
      end
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_rows  = r_perf_rows;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_outfifo_read_sched.sv
// tb_outfifo_read_sched
// Drives two schedulers (4 ports and 2 ports, ROW_W=2, MAT_W=2) from queue
// models of first-word-fall-through FIFOs. Expected row groups are computed
// when a word is pushed and popped as groups are accepted.
module tb_outfifo_read_sched;

  logic CLK;
  logic RST;

  outfifo_read_sched_if #(.NUM_PORTS(4), .MAT_W(2), .ROW_W(2)) ifa();
  outfifo_read_sched_if #(.NUM_PORTS(2), .MAT_W(2), .ROW_W(2)) ifb();

`ifdef OUTFIFO_SCHED_PERF_EN
  logic [31:0] perf_rows_a, perf_stall_a, perf_rows_b, perf_stall_b;
`endif

  outfifo_read_sched #(.NUM_PORTS(4), .MAT_W(2), .ROW_W(2)) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .sched_if   (ifa)
`ifdef OUTFIFO_SCHED_PERF_EN
    ,
    .perf_rows  (perf_rows_a),
    .perf_stall (perf_stall_a)
`endif
  );

  outfifo_read_sched #(.NUM_PORTS(2), .MAT_W(2), .ROW_W(2)) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .sched_if   (ifb)
`ifdef OUTFIFO_SCHED_PERF_EN
    ,
    .perf_rows  (perf_rows_b),
    .perf_stall (perf_stall_b)
`endif
  );

  typedef struct packed {
    logic [3:0] valid;
    logic [7:0] mat_vec;
    logic [7:0] row_vec;
    logic [7:0] sel_mask;
  } grp_t;

  logic [4:0] fa_q[$];
  logic [4:0] fb_q[$];
  grp_t       exp_a[$];
  grp_t       exp_b[$];
  int         pops_a;
  int         pops_b;
  int         n_cmp;
  int         n_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_fifos();
    ifa.instr_FIFO_empty = (fa_q.size() == 0);
    ifa.instr_FIFO_rdata = (fa_q.size() == 0) ? 5'd0 : fa_q[0];
    ifb.instr_FIFO_empty = (fb_q.size() == 0);
    ifb.instr_FIFO_rdata = (fb_q.size() == 0) ? 5'd0 : fb_q[0];
  endtask

  // one clock; the FIFO models pop whatever the DUT requested at that edge
  task automatic step();
    logic ra, rb;
    ra = ifa.instr_FIFO_REN;
    rb = ifb.instr_FIFO_REN;
    @(posedge CLK);
    #1;
    if (ra === 1'b1 && fa_q.size() > 0) begin void'(fa_q.pop_front()); pops_a++; end
    if (rb === 1'b1 && fb_q.size() > 0) begin void'(fb_q.pop_front()); pops_b++; end
    drive_fifos();
    #1;
  endtask

  // queues a word and the row groups it should produce on a np-port block
  task automatic push_word(input bit to_b, input logic [1:0] mat, input logic [2:0] cnt);
    int   np, eff;
    grp_t g;
    np  = to_b ? 2 : 4;
    eff = (int'(cnt) > 4) ? 4 : int'(cnt);
    if (to_b) fb_q.push_back({mat, cnt}); else fa_q.push_back({mat, cnt});
    for (int base = 0; base < eff; base += np) begin
      g = '0;
      for (int i = 0; i < np; i++) begin
        if (base + i < eff) begin
          g.valid[i]          = 1'b1;
          g.mat_vec[2*i +: 2] = mat;
          g.row_vec[2*i +: 2] = 2'(base + i);
          g.sel_mask[2*i +: 2] = 2'b11;
        end
      end
      if (to_b) exp_b.push_back(g); else exp_a.push_back(g);
    end
    drive_fifos();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ifa.issue_ready = 1'b1;
    ifb.issue_ready = 1'b1;
    drive_fifos();
    push_word(1'b0, 2'd1, 3'd2);
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (ifa.instr_FIFO_REN !== 1'b0 || fa_q.size() != 1) begin
      n_err++;
      $display("FAIL reset_ren: REN=%b fifo_left=%0d, want REN=0 fifo_left=1", ifa.instr_FIFO_REN, fa_q.size());
    end
    n_cmp++;
    if (ifa.r_valid !== 4'b0 || ifa.busy !== 1'b0 || ifa.cnt_err !== 1'b0 ||
        ifa.r_mat_sel !== 8'h0 || ifa.r_row_sel !== 8'h0) begin
      n_err++;
      $display("FAIL reset_a: valid=%b busy=%b err=%b mat=%h row=%h, want all 0",
               ifa.r_valid, ifa.busy, ifa.cnt_err, ifa.r_mat_sel, ifa.r_row_sel);
    end
    n_cmp++;
    if (ifb.r_valid !== 2'b0 || ifb.busy !== 1'b0 || ifb.instr_FIFO_REN !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: valid=%b busy=%b REN=%b, want 0", ifb.r_valid, ifb.busy, ifb.instr_FIFO_REN);
    end
    fa_q.delete();
    exp_a.delete();
    drive_fifos();
    RST = 1'b0;
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0 || ifa.instr_FIFO_REN !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b REN=%b, want 0 0", ifa.busy, ifa.instr_FIFO_REN);
    end
  endtask

  task automatic test_single();
    grp_t g;
    int   p0, n_acc, first_c;
    p0 = pops_a; n_acc = 0; first_c = -1;
    push_word(1'b0, 2'd2, 3'd4);
    n_cmp++;
    if (ifa.instr_FIFO_REN !== 1'b1 || ifa.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: REN=%b busy=%b, want 1 0", ifa.instr_FIFO_REN, ifa.busy);
    end
    for (int c = 0; c < 20; c++) begin
      if (ifa.busy === 1'b1 && ifa.issue_ready) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL single_extra: valid=%b with nothing expected", ifa.r_valid);
        end else begin
          g = exp_a.pop_front();
          if (ifa.r_valid !== g.valid || (ifa.r_mat_sel & g.sel_mask) !== g.mat_vec ||
              (ifa.r_row_sel & g.sel_mask) !== g.row_vec) begin
            n_err++;
            $display("FAIL single_grp: got valid=%b mat=%h row=%h want valid=%b mat=%h row=%h",
                     ifa.r_valid, ifa.r_mat_sel & g.sel_mask, ifa.r_row_sel & g.sel_mask,
                     g.valid, g.mat_vec, g.row_vec);
          end
        end
        if (first_c < 0) first_c = c;
        n_acc++;
      end else if (fa_q.size() == 0 && exp_a.size() == 0 && ifa.busy !== 1'b1) break;
      step();
    end
    n_cmp++;
    if (n_acc != 1 || first_c != 1 || pops_a - p0 != 1) begin
      n_err++;
      $display("FAIL single_timing: groups=%0d first_cycle=%0d pops=%0d, want 1 1 1", n_acc, first_c, pops_a - p0);
    end
    n_cmp++;
    if (ifa.busy !== 1'b0 || ifa.r_valid !== 4'b0 || ifa.cnt_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: busy=%b valid=%b err=%b, want 0 0000 0", ifa.busy, ifa.r_valid, ifa.cnt_err);
    end
  endtask

  task automatic test_two_port();
    grp_t g;
    int   p0, n_acc;
    int   acc_c[4];
    p0 = pops_b; n_acc = 0;
    acc_c = '{default: 0};
    push_word(1'b1, 2'd1, 3'd3);
    for (int c = 0; c < 20; c++) begin
      if (ifb.busy === 1'b1 && ifb.issue_ready) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL two_port_extra: valid=%b with nothing expected", ifb.r_valid);
        end else begin
          g = exp_b.pop_front();
          if ({2'b00, ifb.r_valid} !== g.valid || ({4'h0, ifb.r_mat_sel} & g.sel_mask) !== g.mat_vec ||
              ({4'h0, ifb.r_row_sel} & g.sel_mask) !== g.row_vec) begin
            n_err++;
            $display("FAIL two_port_grp%0d: got valid=%b mat=%h row=%h want valid=%b mat=%h row=%h",
                     n_acc, ifb.r_valid, {4'h0, ifb.r_mat_sel} & g.sel_mask,
                     {4'h0, ifb.r_row_sel} & g.sel_mask, g.valid, g.mat_vec, g.row_vec);
          end
        end
        if (n_acc < 4) acc_c[n_acc] = c;
        n_acc++;
      end else if (fb_q.size() == 0 && exp_b.size() == 0 && ifb.busy !== 1'b1) break;
      step();
    end
    n_cmp++;
    if (n_acc != 2 || acc_c[1] - acc_c[0] != 1 || pops_b - p0 != 1 || ifb.busy !== 1'b0) begin
      n_err++;
      $display("FAIL two_port_seq: groups=%0d gap=%0d pops=%0d busy=%b, want 2 1 1 0",
               n_acc, acc_c[1] - acc_c[0], pops_b - p0, ifb.busy);
    end
  endtask

  task automatic test_stall();
    grp_t g;
    push_word(1'b1, 2'd2, 3'd4);
    step();
    g = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
    n_cmp++;
    if (ifb.busy !== 1'b1 || {2'b00, ifb.r_valid} !== g.valid ||
        ({4'h0, ifb.r_row_sel} & g.sel_mask) !== g.row_vec) begin
      n_err++;
      $display("FAIL stall_grp0: busy=%b valid=%b row=%h, want 1 %b %h",
               ifb.busy, ifb.r_valid, {4'h0, ifb.r_row_sel} & g.sel_mask, g.valid, g.row_vec);
    end
    step();
    ifb.issue_ready = 1'b0;
    #1;
    g = (exp_b.size() > 0) ? exp_b[0] : '0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ifb.busy !== 1'b1 || ifb.instr_FIFO_REN !== 1'b0 || {2'b00, ifb.r_valid} !== g.valid ||
          ({4'h0, ifb.r_mat_sel} & g.sel_mask) !== g.mat_vec ||
          ({4'h0, ifb.r_row_sel} & g.sel_mask) !== g.row_vec) begin
        n_err++;
        $display("FAIL stall_hold%0d: busy=%b REN=%b valid=%b mat=%h row=%h want 1 0 %b %h %h",
                 k, ifb.busy, ifb.instr_FIFO_REN, ifb.r_valid, {4'h0, ifb.r_mat_sel} & g.sel_mask,
                 {4'h0, ifb.r_row_sel} & g.sel_mask, g.valid, g.mat_vec, g.row_vec);
      end
      step();
    end
    ifb.issue_ready = 1'b1;
    #1;
    g = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
    n_cmp++;
    if ({2'b00, ifb.r_valid} !== g.valid || ({4'h0, ifb.r_row_sel} & g.sel_mask) !== g.row_vec) begin
      n_err++;
      $display("FAIL stall_release: valid=%b row=%h, want %b %h",
               ifb.r_valid, {4'h0, ifb.r_row_sel} & g.sel_mask, g.valid, g.row_vec);
    end
    step();
    n_cmp++;
    if (ifb.busy !== 1'b0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL stall_end: busy=%b left=%0d, want 0 0", ifb.busy, exp_b.size());
    end
  endtask

`ifdef OUTFIFO_SCHED_PERF_EN
  task automatic test_perf();
    n_cmp++;
    if (perf_rows_b !== 32'd7 || perf_stall_b !== 32'd3) begin
      n_err++;
      $display("FAIL perf_b: rows=%0d stall=%0d, want 7 3", perf_rows_b, perf_stall_b);
    end
    n_cmp++;
    if (perf_rows_a !== 32'd4 || perf_stall_a !== 32'd0) begin
      n_err++;
      $display("FAIL perf_a: rows=%0d stall=%0d, want 4 0", perf_rows_a, perf_stall_a);
    end
  endtask
`endif

  task automatic test_back_to_back();
    grp_t g;
    int   p0, n_acc;
    int   acc_c[4];
    logic ren_first;
    p0 = pops_a; n_acc = 0; ren_first = 1'b0;
    acc_c = '{default: 0};
    push_word(1'b0, 2'd0, 3'd4);
    push_word(1'b0, 2'd3, 3'd4);
    for (int c = 0; c < 20; c++) begin
      if (ifa.busy === 1'b1 && ifa.issue_ready) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: valid=%b with nothing expected", ifa.r_valid);
        end else begin
          g = exp_a.pop_front();
          if (ifa.r_valid !== g.valid || (ifa.r_mat_sel & g.sel_mask) !== g.mat_vec ||
              (ifa.r_row_sel & g.sel_mask) !== g.row_vec) begin
            n_err++;
            $display("FAIL b2b_grp%0d: got valid=%b mat=%h row=%h want valid=%b mat=%h row=%h",
                     n_acc, ifa.r_valid, ifa.r_mat_sel & g.sel_mask, ifa.r_row_sel & g.sel_mask,
                     g.valid, g.mat_vec, g.row_vec);
          end
        end
        if (n_acc == 0) ren_first = ifa.instr_FIFO_REN;
        if (n_acc < 4) acc_c[n_acc] = c;
        n_acc++;
      end else if (fa_q.size() == 0 && exp_a.size() == 0 && ifa.busy !== 1'b1) break;
      step();
    end
    n_cmp++;
    if (n_acc != 2 || ren_first !== 1'b1 || acc_c[1] - acc_c[0] != 1 || pops_a - p0 != 2) begin
      n_err++;
      $display("FAIL b2b_seq: groups=%0d REN_at_first=%b gap=%0d pops=%0d, want 2 1 1 2",
               n_acc, ren_first, acc_c[1] - acc_c[0], pops_a - p0);
    end
  endtask

  task automatic test_cnt_edge();
    grp_t g;
    int   n_acc;
    n_acc = 0;
    push_word(1'b0, 2'd1, 3'd0);
    push_word(1'b0, 2'd2, 3'd7);
    for (int c = 0; c < 20; c++) begin
      if (c == 1) begin
        n_cmp++;
        if (ifa.busy !== 1'b0 || ifa.r_valid !== 4'b0 || ifa.cnt_err !== 1'b0 || ifa.instr_FIFO_REN !== 1'b1) begin
          n_err++;
          $display("FAIL zero_cnt: busy=%b valid=%b err=%b REN=%b, want 0 0000 0 1",
                   ifa.busy, ifa.r_valid, ifa.cnt_err, ifa.instr_FIFO_REN);
        end
      end
      if (ifa.busy === 1'b1 && ifa.issue_ready) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL clamp_extra: valid=%b with nothing expected", ifa.r_valid);
        end else begin
          g = exp_a.pop_front();
          if (ifa.r_valid !== g.valid || (ifa.r_mat_sel & g.sel_mask) !== g.mat_vec ||
              (ifa.r_row_sel & g.sel_mask) !== g.row_vec) begin
            n_err++;
            $display("FAIL clamp_grp: got valid=%b mat=%h row=%h want valid=%b mat=%h row=%h",
                     ifa.r_valid, ifa.r_mat_sel & g.sel_mask, ifa.r_row_sel & g.sel_mask,
                     g.valid, g.mat_vec, g.row_vec);
          end
        end
        n_acc++;
      end else if (fa_q.size() == 0 && exp_a.size() == 0 && ifa.busy !== 1'b1) break;
      step();
    end
    n_cmp++;
    if (n_acc != 1 || ifa.cnt_err !== 1'b1 || ifa.instr_FIFO_REN !== 1'b0) begin
      n_err++;
      $display("FAIL clamp_end: groups=%0d err=%b REN=%b, want 1 1 0", n_acc, ifa.cnt_err, ifa.instr_FIFO_REN);
    end
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (ifa.cnt_err !== 1'b1 || ifa.busy !== 1'b0) begin
      n_err++;
      $display("FAIL err_sticky: err=%b busy=%b, want 1 0", ifa.cnt_err, ifa.busy);
    end
  endtask

  task automatic test_reset_mid_issue();
    grp_t g;
    int   p0;
    push_word(1'b0, 2'd3, 3'd4);
    push_word(1'b0, 2'd1, 3'd2);
    step();
    p0 = pops_a;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (ifa.busy !== 1'b1 || ifa.instr_FIFO_REN !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_ren: busy=%b REN=%b, want 1 0", ifa.busy, ifa.instr_FIFO_REN);
    end
    step();
    n_cmp++;
    if (ifa.r_valid !== 4'b0 || ifa.busy !== 1'b0 || ifa.cnt_err !== 1'b0 || ifa.instr_FIFO_REN !== 1'b0 ||
        ifa.r_mat_sel !== 8'h0 || ifa.r_row_sel !== 8'h0 || pops_a != p0 || fa_q.size() != 1) begin
      n_err++;
      $display("FAIL rst_mid_state: valid=%b busy=%b err=%b REN=%b mat=%h row=%h pops=%0d left=%0d, want 0 0 0 0 0 0 0 1",
               ifa.r_valid, ifa.busy, ifa.cnt_err, ifa.instr_FIFO_REN, ifa.r_mat_sel, ifa.r_row_sel,
               pops_a - p0, fa_q.size());
    end
    if (exp_a.size() > 0) void'(exp_a.pop_front());
    RST = 1'b0;
    #1;
    n_cmp++;
    if (ifa.busy !== 1'b0 || ifa.instr_FIFO_REN !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_idle: busy=%b REN=%b, want 0 1", ifa.busy, ifa.instr_FIFO_REN);
    end
    step();
    g = (exp_a.size() > 0) ? exp_a.pop_front() : '0;
    n_cmp++;
    if (ifa.r_valid !== g.valid || (ifa.r_mat_sel & g.sel_mask) !== g.mat_vec ||
        (ifa.r_row_sel & g.sel_mask) !== g.row_vec) begin
      n_err++;
      $display("FAIL rst_mid_next: got valid=%b mat=%h row=%h want valid=%b mat=%h row=%h",
               ifa.r_valid, ifa.r_mat_sel & g.sel_mask, ifa.r_row_sel & g.sel_mask,
               g.valid, g.mat_vec, g.row_vec);
    end
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_end: busy=%b left=%0d, want 0 0", ifa.busy, exp_a.size());
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    pops_a = 0;
    pops_b = 0;
    test_reset();
    test_single();
    test_two_port();
    test_stall();
`ifdef OUTFIFO_SCHED_PERF_EN
    test_perf();
`endif
    test_back_to_back();
    test_cnt_edge();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/outfifo_read_sched.md
OUTFIFO_READ_SCHED -- requirements
Module: outfifo_read_sched

Interface
REQ-001 The block SHALL take parameter NUM_PORTS, default 4, meaning the number of scratchpad read ports driven per cycle.
REQ-002 The block SHALL take parameter MAT_W, default 2, meaning the matrix-select width (mat_s_t).
REQ-003 The block SHALL take parameter ROW_W, default 2, meaning the row-select width (row_s_t); ROWS_PER_MAT = 2**ROW_W.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port instr_FIFO_empty, input, 1, meaning the instruction FIFO is empty.
REQ-007 The block SHALL have port instr_FIFO_rdata, input, MAT_W+ROW_W+1, meaning the head word {mat, row_cnt}; it is first-word-fall-through and valid whenever !instr_FIFO_empty.
REQ-008 The block SHALL have port instr_FIFO_REN, output, 1, meaning pop the head word.
REQ-009 The block SHALL have port issue_ready, input, 1, meaning the downstream accepts the current row group.
REQ-010 The block SHALL have port r_valid, output, NUM_PORTS, meaning per-port read valid.
REQ-011 The block SHALL have port r_mat_sel, output, NUM_PORTS*MAT_W, meaning per-port matrix select.
REQ-012 The block SHALL have port r_row_sel, output, NUM_PORTS*ROW_W, meaning per-port row select.
REQ-013 The block SHALL have port busy, output, 1, meaning the FSM is not IDLE.
REQ-014 The block SHALL have port cnt_err, output, 1, a sticky flag set when row_cnt exceeds ROWS_PER_MAT.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and ISSUE.
REQ-016 In IDLE with !instr_FIFO_empty, instr_FIFO_REN SHALL be 1 for one cycle, the block SHALL latch mat and row_cnt, SHALL set base=0, and SHALL go to ISSUE; the first r_valid appears the next cycle.
REQ-017 A popped row_cnt=0 SHALL be discarded, the FSM SHALL stay in IDLE, and no r_valid SHALL be asserted.
REQ-018 A row_cnt>ROWS_PER_MAT SHALL be clamped to ROWS_PER_MAT and SHALL set cnt_err.
REQ-019 In ISSUE, port i SHALL assert r_valid[i] iff base+i<cnt, with r_row_sel[i]=base+i and r_mat_sel[i]=latched mat.
REQ-020 When issue_ready=0, all ISSUE outputs SHALL hold stable and base SHALL NOT advance.
REQ-021 When issue_ready=1, base SHALL advance by NUM_PORTS; if base+NUM_PORTS>=cnt, the group is the last one.
REQ-022 On the last group accepted with !instr_FIFO_empty, the block SHALL pop the next word that same cycle and SHALL stay in ISSUE with base=0 (back-to-back, no bubble); otherwise it SHALL go to IDLE.
REQ-023 instr_FIFO_REN SHALL never be asserted while instr_FIFO_empty=1.
REQ-024 Base arithmetic SHALL use ROW_W+1 bits so that no wrap-around occurs at ROWS_PER_MAT.

Reset
REQ-025 While RST=1 at a clock edge, the block SHALL enter IDLE, and r_valid, instr_FIFO_REN, busy, cnt_err, r_mat_sel and r_row_sel SHALL all be 0.
REQ-026 A reset mid-ISSUE SHALL abandon the instruction without a further pop.
REQ-027 After a reset mid-ISSUE, the first cycle after RST deasserts SHALL behave as IDLE.

Configuration
REQ-028 With OUTFIFO_SCHED_PERF_EN defined, the block SHALL add 32-bit outputs perf_rows (total rows accepted) and perf_stall (cycles in ISSUE with issue_ready=0), both reset to 0 and saturating at all-ones.
REQ-029 Without OUTFIFO_SCHED_PERF_EN, these outputs and their counters SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-030 Scenario: NUM_PORTS=4, ROW_W=2, word {mat=2,cnt=4}, issue_ready=1 -> one REN pulse; next cycle r_valid=1111, rows 0..3, mat=2; then IDLE.
REQ-031 Scenario: NUM_PORTS=2, word {mat=1,cnt=3} -> group 1: r_valid=11, rows 0,1; group 2: r_valid=01, row 2; then IDLE.
REQ-032 Scenario: issue_ready held 0 for 3 cycles mid-instruction -> outputs unchanged for all 3 cycles; perf_stall increases by 3 when the macro is defined.
REQ-033 Scenario: two words queued, {0,4} then {3,4}, issue_ready=1 -> second REN in the same cycle as the first group is accepted; groups on consecutive cycles with no gap.
REQ-034 Scenario: word cnt=0, then word cnt=7 with ROW_W=2 -> the first produces no valid; the second issues 4 rows and cnt_err=1 until reset.
REQ-035 Scenario: RST pulsed during ISSUE -> next cycle r_valid=0, busy=0, cnt_err=0, and no REN while RST=1.
